// File: rtl/spi_master_param.sv
// SPI master: valid/ready word in, CPOL/CPHA chosen per transfer, one of NUM_CS selects.
// Optional feature macro SPI_LOOPBACK_EN adds a loopback input that feeds mosi back into the receiver.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [$clog2(NUM_CS):0] cs_sel,
  input  logic                    cpol,
  input  logic                    cpha,
  output logic [DATA_W-1:0]       rx_data,
  output logic                    rx_valid,
  output logic                    busy,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
`ifdef SPI_LOOPBACK_EN
  input  logic                    loopback,
`endif
  output logic [NUM_CS-1:0]       cs_n
);

  localparam int CSW   = $clog2(NUM_CS) + 1;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int EW    = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [EW-1:0]       edge_cnt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   rx_sh;
  logic                cpha_q;
  logic                accept, div_last, edge_last, edge_evt, lead;
  logic                sample_evt, shift_evt, rx_bit;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) m[i] = (sel != CSW'(i));
    return m;
  endfunction

  assign tx_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = tx_valid && tx_ready;
  assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign edge_last = (edge_cnt == EW'(2 * DATA_W - 1));
  assign edge_evt  = (state == S_XFER) && div_last;
  assign lead      = ~edge_cnt[0];
  // Sampling edge is the leading one in CPHA=0 and the trailing one in CPHA=1;
  // mosi moves on the other edge, skipping the edge that would run past the LSB.
  assign sample_evt = edge_evt && (lead ^ cpha_q);
  assign shift_evt  = edge_evt && !(lead ^ cpha_q) && !edge_last && (edge_cnt != '0);
  assign mosi       = shreg[DATA_W-1];

`ifdef SPI_LOOPBACK_EN
  logic lb_q;
  assign rx_bit = lb_q ? mosi : miso;
`else
  assign rx_bit = miso;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tx_valid)              state_nxt = S_SETUP;
      S_SETUP: if (div_last)              state_nxt = S_XFER;
      S_XFER:  if (div_last && edge_last) state_nxt = S_HOLD;
      S_HOLD:  if (div_last)              state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      shreg    <= '0;
      cpha_q   <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= '1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
`ifdef SPI_LOOPBACK_EN
      lb_q     <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (state == S_IDLE || div_last) div_cnt <= '0;
      else                             div_cnt <= div_cnt + DIV_W'(1);
      if (state != S_XFER) edge_cnt <= '0;
      else if (edge_evt)   edge_cnt <= edge_cnt + EW'(1);
      if (accept) begin
        shreg  <= tx_data;
        cpha_q <= cpha;
        sclk   <= cpol;
        cs_n   <= cs_decode(cs_sel);
`ifdef SPI_LOOPBACK_EN
        lb_q   <= loopback;
`endif
      end else if (state == S_IDLE) begin
        sclk <= cpol;
      end
      if (edge_evt)  sclk  <= ~sclk;
      if (shift_evt) shreg <= {shreg[DATA_W-2:0], 1'b0};
      if (state == S_HOLD && div_last) begin
        cs_n     <= '1;
        rx_valid <= 1'b1;
        rx_data  <= rx_sh;
      end
    end
  end

  // Receive shifter carries data only; it is fully overwritten every word.
  always_ff @(posedge clk) begin
    if (sample_evt) rx_sh <= {rx_sh[DATA_W-2:0], rx_bit};
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: two instances (CLK_DIV=4/NUM_CS=2 and CLK_DIV=1/NUM_CS=1)
// driven in turn, with a behavioural SPI slave and cycle-level timing expectations.
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [1:0] cs_sel = 2'b00;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       miso;
`ifdef SPI_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif
  int         cur = 0;

  logic       tv0, tv1;
  logic       rdy0, rdy1, rv0, rv1, bsy0, bsy1, sck0, sck1, mo0, mo1;
  logic [7:0] rd0, rd1;
  logic [1:0] csn0;
  logic [0:0] csn1;

  logic       m_ready, m_rx_valid, m_busy, m_sclk, m_mosi;
  logic [7:0] m_rx_data;
  logic [1:0] m_cs_n;

  int total = 0;
  int bad   = 0;

  logic [7:0] slv_q[$];
  logic [7:0] cap_q[$];
  int         edge_q[$];
  logic       slv_cpol = 1'b0;
  logic       slv_cpha = 1'b0;

  assign tv0 = tx_valid && (cur == 0);
  assign tv1 = tx_valid && (cur == 1);

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(2)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tv0), .tx_ready(rdy0),
    .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .rx_data(rd0), .rx_valid(rv0),
    .busy(bsy0), .sclk(sck0), .mosi(mo0), .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cs_n(csn0)
  );

  spi_master_param #(.DATA_W(8), .CLK_DIV(1), .NUM_CS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tv1), .tx_ready(rdy1),
    .cs_sel(cs_sel[0]), .cpol(cpol), .cpha(cpha), .rx_data(rd1), .rx_valid(rv1),
    .busy(bsy1), .sclk(sck1), .mosi(mo1), .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cs_n(csn1)
  );

  assign m_ready    = (cur == 0) ? rdy0 : rdy1;
  assign m_rx_valid = (cur == 0) ? rv0  : rv1;
  assign m_busy     = (cur == 0) ? bsy0 : bsy1;
  assign m_sclk     = (cur == 0) ? sck0 : sck1;
  assign m_mosi     = (cur == 0) ? mo0  : mo1;
  assign m_rx_data  = (cur == 0) ? rd0  : rd1;
  assign m_cs_n     = (cur == 0) ? csn0 : {1'b1, csn1[0]};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // SPI slave: returns the next queued word and records what it saw on mosi.
  initial begin : slave
    logic       pb, ps;
    logic [7:0] w, r;
    int         idx, ne;
    pb = 1'b0; ps = 1'b0; w = '0; r = '0; idx = 0; ne = 0;
    miso = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pb   = 1'b0;
        miso = 1'b0;
      end else begin
        if (m_busy && !pb) begin
          w   = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
          r   = '0;
          ne  = 0;
          idx = 7;
          if (!slv_cpha) begin
            miso = w[7];
            idx  = 6;
          end
        end else if (m_busy && (m_sclk !== ps)) begin
          ne++;
          if ((m_sclk != slv_cpol) ^ slv_cpha) r = {r[6:0], m_mosi};
          else if (idx >= 0) begin
            miso = w[idx];
            idx--;
          end
        end else if (!m_busy && pb) begin
          cap_q.push_back(r);
          edge_q.push_back(ne);
        end
        pb = m_busy;
      end
      ps = m_sclk;
    end
  end

  task automatic pop_slave(input string tag, input logic [7:0] exp_mosi);
    logic [7:0] cap;
    int         ne;
    cap = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
    ne  = (edge_q.size() > 0) ? edge_q.pop_front() : -1;
    chk({tag, "_mosi_word"}, 32'(cap), 32'(exp_mosi));
    chk({tag, "_sclk_edges"}, 32'(ne), 32'd16);
  endtask

  task automatic xfer(input string tag, input int which, input logic [7:0] tx,
                      input logic p, input logic h, input logic [7:0] sw,
                      input logic [1:0] sel, input logic lb);
    int         div, t_end, rxv_at, npulse;
    logic [1:0] exp_cs;
    logic [7:0] exp_rx;
    div    = (which == 0) ? 4 : 1;
    t_end  = div * (2 * 8 + 2);
    exp_cs = 2'b11;
    if (which == 0) begin
      if (sel < 2'd2) exp_cs[sel[0]] = 1'b0;
    end else if (sel[0] == 1'b0) begin
      exp_cs[0] = 1'b0;
    end
    exp_rx   = lb ? tx : sw;
    cur      = which;
    slv_cpol = p;
    slv_cpha = h;
    slv_q.push_back(sw);
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(m_ready), 32'd1);
    tx_data = tx; cpol = p; cpha = h; cs_sel = sel; tx_valid = 1'b1;
`ifdef SPI_LOOPBACK_EN
    loopback = lb;
`endif
    @(posedge clk);
    #1;
    tx_valid = 1'b0; tx_data = ~tx; cpol = ~p; cpha = ~h; cs_sel = sel ^ 2'b01;
`ifdef SPI_LOOPBACK_EN
    loopback = ~lb;
`endif
    rxv_at = -1;
    npulse = 0;
    for (int n = 1; n <= t_end + 3; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk({tag, "_cs_first"}, 32'(m_cs_n), 32'(exp_cs));
        chk({tag, "_sclk_setup"}, 32'(m_sclk), 32'(p));
        chk({tag, "_mosi_msb"}, 32'(m_mosi), 32'(tx[7]));
        chk({tag, "_busy"}, 32'(m_busy), 32'd1);
        chk({tag, "_ready_busy"}, 32'(m_ready), 32'd0);
      end
      if (n == t_end) begin
        chk({tag, "_cs_last"}, 32'(m_cs_n), 32'(exp_cs));
        chk({tag, "_sclk_hold"}, 32'(m_sclk), 32'(p));
      end
      if (n == t_end + 1) begin
        chk({tag, "_cs_release"}, 32'(m_cs_n), 32'h3);
        chk({tag, "_busy_end"}, 32'(m_busy), 32'd0);
      end
      if (m_rx_valid) begin
        npulse++;
        if (rxv_at < 0) rxv_at = n;
      end
    end
    chk({tag, "_rx_valid_cycle"}, 32'(rxv_at), 32'(t_end + 1));
    chk({tag, "_rx_valid_pulses"}, 32'(npulse), 32'd1);
    chk({tag, "_rx_data"}, 32'(m_rx_data), 32'(exp_rx));
    pop_slave(tag, tx);
  endtask

  initial begin : stim
    int         p1, p2, np, cs0_low, gap;
    logic [7:0] d1, d2, w1, w2, rtx;
    p1 = -1; p2 = -1; np = 0; cs0_low = 0; gap = 0; d1 = '0; d2 = '0;

    // reset values on both instances
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cur = i;
      #1;
      chk("rst_ready", 32'(m_ready), 32'd1);
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_rx_valid", 32'(m_rx_valid), 32'd0);
      chk("rst_rx_data", 32'(m_rx_data), 32'd0);
      chk("rst_sclk", 32'(m_sclk), 32'd0);
      chk("rst_mosi", 32'(m_mosi), 32'd0);
      chk("rst_cs_n", 32'(m_cs_n), 32'h3);
    end
    cur = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    xfer("mode0_a5", 0, 8'hA5, 1'b0, 1'b0, 8'h3C, 2'd0, 1'b0);
    xfer("mode3_81", 0, 8'h81, 1'b1, 1'b1, 8'h7E, 2'd0, 1'b0);
    xfer("div1_mode1", 1, 8'hFF, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0);
    xfer("cs_out_of_range", 0, 8'h6B, 1'b0, 1'b1, 8'hD2, 2'd2, 1'b0);

    // back-to-back with tx_valid held, second word presented while busy
    cur = 0; slv_cpol = 1'b0; slv_cpha = 1'b0;
    w1 = 8'($urandom_range(0, 255));
    w2 = 8'($urandom_range(0, 255));
    slv_q.push_back(w1);
    slv_q.push_back(w2);
    @(negedge clk);
    tx_data = 8'h11; cs_sel = 2'd1; cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'h22;
    for (int n = 1; n <= 2 * 72 + 4; n++) begin
      @(negedge clk);
      if (m_cs_n[0] == 1'b0) cs0_low++;
      if (n > 36 && n < 108 && m_cs_n[1]) gap++;
      if (m_rx_valid) begin
        np++;
        if (p1 < 0) begin p1 = n; d1 = m_rx_data; end
        else begin p2 = n; d2 = m_rx_data; end
      end
      if (n == 74) tx_valid = 1'b0;
    end
    chk("b2b_first_valid", 32'(p1), 32'd73);
    chk("b2b_second_valid", 32'(p2), 32'd146);
    chk("b2b_pulses", 32'(np), 32'd2);
    chk("b2b_rx_first", 32'(d1), 32'(w1));
    chk("b2b_rx_second", 32'(d2), 32'(w2));
    chk("b2b_cs0_untouched", 32'(cs0_low), 32'd0);
    chk("b2b_cs1_gap", 32'(gap), 32'd1);
    pop_slave("b2b_first", 8'h11);
    pop_slave("b2b_second", 8'h22);

    // reset in the middle of a transfer
    cur = 0; slv_cpol = 1'b0; slv_cpha = 1'b0;
    slv_q.push_back(8'hC3);
    @(negedge clk);
    tx_data = 8'hF0; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_cs_n", 32'(m_cs_n), 32'h3);
    chk("abort_sclk", 32'(m_sclk), 32'd0);
    chk("abort_ready", 32'(m_ready), 32'd1);
    chk("abort_busy", 32'(m_busy), 32'd0);
    chk("abort_mosi", 32'(m_mosi), 32'd0);
    chk("abort_rx_data", 32'(m_rx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    np = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (m_rx_valid) np++;
    end
    chk("abort_no_rx_valid", 32'(np), 32'd0);
    chk("abort_no_slave_frame", 32'(cap_q.size()), 32'd0);
    xfer("after_abort", 0, 8'h3A, 1'b0, 1'b0, 8'h95, 2'd0, 1'b0);

`ifdef SPI_LOOPBACK_EN
    xfer("loopback_5a", 0, 8'h5A, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
`endif

    // randomized transfers across both instances and all modes
    for (int k = 0; k < 8; k++) begin
      int         which;
      logic [1:0] sel;
      logic       lb;
      which = int'($urandom_range(0, 1));
      sel   = (which == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
      rtx   = 8'($urandom_range(0, 255));
      lb    = 1'b0;
`ifdef SPI_LOOPBACK_EN
      lb    = 1'($urandom_range(0, 1));
`endif
      xfer("random", which, rtx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), sel, lb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
